// File: rtl/ucode_type_decode_q.sv
// ucode_type_decode_q
// Registered, flow-controlled uCode instruction-type decoder. A control-word
// type field is decoded into a one-hot type vector on the way in. The result
// is held in a 2-entry (main + skid) buffer behind a valid/ready handshake.
// Out-of-range codes are flagged as illegal. Saturating per-type issue
// counters can be read back through a combinational select port.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   cw_type       type code from the control word
//   test_jmp_ld   1 = decode cw_type, 0 = entry is a NOP (all-zero type)
//   in_valid      upstream entry valid
//   in_ready      registered: block can accept an entry this cycle
//   out_type      one-hot type of the head entry
//   out_illegal   head entry carried an out-of-range code
//   out_valid     head entry valid
//   out_ready     downstream accepts the head entry
//   flush         synchronous discard of all buffered entries
//   cnt_sel       counter select for readout
//   cnt_value     selected counter, 0 for an out-of-range select
//   cnt_clr       synchronous clear of all counters
module ucode_type_decode_q #(
  parameter int TYPE_W    = 4,
  parameter int NUM_TYPES = 10,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TYPE_W-1:0]    cw_type,
  input  logic                 test_jmp_ld,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NUM_TYPES-1:0] out_type,
  output logic                 out_illegal,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  input  logic [TYPE_W-1:0]    cnt_sel,
  output logic [CNT_W-1:0]     cnt_value,
  input  logic                 cnt_clr
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // One extra bit so the range check still works when NUM_TYPES == 2**TYPE_W.
  localparam logic [TYPE_W:0] NUM_TYPES_EXT = (TYPE_W+1)'(NUM_TYPES);

  state_t state, state_next;

  logic                 accept;
  logic                 issue;
  logic [NUM_TYPES-1:0] dec_type;
  logic                 dec_illegal;
  logic [NUM_TYPES-1:0] main_type;
  logic                 main_illegal;
  logic [NUM_TYPES-1:0] skid_type;
  logic                 skid_illegal;
  logic                 load_main_in;
  logic                 load_main_skid;
  logic                 load_skid;
  logic                 clear_main;
  logic                 ready_q;
  logic [CNT_W-1:0]     cnt [NUM_TYPES];

  assign accept      = in_valid & ready_q;
  assign issue       = (state != EMPTY) & out_ready;
  assign in_ready    = ready_q;
  assign out_valid   = (state != EMPTY);
  assign out_type    = main_type;
  assign out_illegal = main_illegal;

  // Decode at the input so both buffer slots hold ready-to-use results.
  always_comb begin
    dec_type    = '0;
    dec_illegal = 1'b0;
    if (test_jmp_ld) begin
      if ({1'b0, cw_type} < NUM_TYPES_EXT) begin
        dec_type = NUM_TYPES'(1) << cw_type;
      end else begin
        dec_illegal = 1'b1;
      end
    end
  end

  // Occupancy FSM: next state and buffer load controls.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    clear_main     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && !issue) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (issue && !accept) begin
          state_next = EMPTY;
          clear_main = 1'b1;
        end else if (accept && issue) begin
          load_main_in = 1'b1;
        end
      end
      TWO: begin
        if (issue) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
        clear_main = 1'b1;
      end
    endcase
    // Flush drops everything, including an entry accepted this same cycle.
    if (flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      clear_main     = 1'b1;
    end
  end

  // State register plus registered in_ready (low only when both slots are full).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      ready_q <= (state_next != TWO);
    end
  end

  // Main slot is the visible head; it is cleared when the buffer empties so
  // out_type/out_illegal read 0 whenever out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_type    <= '0;
      main_illegal <= 1'b0;
      skid_type    <= '0;
      skid_illegal <= 1'b0;
    end else begin
      if (clear_main) begin
        main_type    <= '0;
        main_illegal <= 1'b0;
      end else if (load_main_in) begin
        main_type    <= dec_type;
        main_illegal <= dec_illegal;
      end else if (load_main_skid) begin
        main_type    <= skid_type;
        main_illegal <= skid_illegal;
      end
      if (load_skid) begin
        skid_type    <= dec_type;
        skid_illegal <= dec_illegal;
      end
    end
  end

  // Per-type issue counters. The head is one-hot (or zero for NOP/illegal),
  // so each counter simply watches its own bit. Clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_TYPES; n++) begin
        cnt[n] <= '0;
      end
    end else if (cnt_clr) begin
      for (int n = 0; n < NUM_TYPES; n++) begin
        cnt[n] <= '0;
      end
    end else if (issue) begin
      for (int n = 0; n < NUM_TYPES; n++) begin
        if (main_type[n] && (cnt[n] != '1)) begin
          cnt[n] <= cnt[n] + CNT_W'(1);
        end
      end
    end
  end

  // Readout mux; selects outside the legal range read as zero.
  always_comb begin
    cnt_value = '0;
    for (int n = 0; n < NUM_TYPES; n++) begin
      if (cnt_sel == TYPE_W'(n)) begin
        cnt_value = cnt[n];
      end
    end
  end

endmodule
